// File: rtl/sign_wbuf_pkg.sv
// Shared widths, FIFO entry layout and ack FSM states for the signature word buffer.
package sign_wbuf_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned SIZE_W     = 6;
    localparam int unsigned BITS_W     = 7;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned FILL_W     = PTR_W + 1;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [BITS_W-1:0] bits;
        logic              last;
    } entry_t;

    typedef enum logic {
        L_IDLE,
        L_ACK
    } ack_state_e;

endpackage

// File: rtl/sign_wbuf_if.sv
// Output word stream: valid/ready handshake carrying the buffered word and its metadata.
interface sign_wbuf_if;
    import sign_wbuf_pkg::*;

    logic [WORD_W-1:0] word_out;
    logic [BITS_W-1:0] word_bits;
    logic              word_last;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_out,
        output word_bits,
        output word_last,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_bits,
        input  word_last,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/sign_fifo.sv
// 8-deep synchronous FIFO of signature entries; head is read combinationally from storage.
module sign_fifo
    import sign_wbuf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  entry_t            wr_entry_i,
    input  logic              rd_en_i,
    output entry_t            head_o,
    output logic [FILL_W-1:0] fill_o
);

    entry_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_entry_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en_i && !rd_en_i) begin
            fill_d = fill_q + 1'b1;
        end else if (rd_en_i && !wr_en_i) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign fill_o = fill_q;

endmodule

// File: rtl/sign_wbuf.sv
// Signature word buffer: arbitrates full and partial-last words from the deserializer into a FIFO.
module sign_wbuf
    import sign_wbuf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [WORD_W-1:0] sign_in,
    input  logic [SIZE_W-1:0] size_in,
    input  logic              des_wr,
    input  logic              last_wr,
    output logic              last_ack,
    sign_wbuf_if.master       word_if,
    output logic [FILL_W-1:0] fill,
    output logic              overflow
);

    ack_state_e        state_q, state_d;
    logic              overflow_q, overflow_d;
    logic              wr_en;
    entry_t            wr_entry;
    entry_t            head;
    logic              word_valid;
    logic              rd_en;
    logic              slot_free;

    assign word_valid = (fill != '0);
    assign rd_en      = word_valid && word_if.word_ready;
    // A pop in the same cycle frees the slot a write needs.
    assign slot_free  = (fill != FILL_W'(FIFO_DEPTH)) || rd_en;

    always_comb begin
        state_d       = state_q;
        overflow_d    = overflow_q;
        wr_en         = 1'b0;
        wr_entry.data = sign_in;
        wr_entry.bits = BITS_W'(WORD_W);
        wr_entry.last = 1'b0;
        if (clk_en) begin
            unique case (state_q)
                L_IDLE: begin
                    if (des_wr) begin
                        if (slot_free) begin
                            wr_en = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (last_wr) begin
                        if (size_in == '0) begin
                            state_d = L_ACK;
                        end else if (slot_free) begin
                            wr_en         = 1'b1;
                            wr_entry.bits = {1'b0, size_in};
                            wr_entry.last = 1'b1;
                            state_d       = L_ACK;
                        end
                    end
                end
                L_ACK: begin
                    state_d = L_IDLE;
                    if (des_wr) begin
                        if (slot_free) begin
                            wr_en = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                default: state_d = L_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= L_IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    sign_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_entry_i (wr_entry),
        .rd_en_i    (rd_en),
        .head_o     (head),
        .fill_o     (fill)
    );

    assign last_ack           = (state_q == L_ACK);
    assign overflow           = overflow_q;
    assign word_if.word_out   = head.data;
    assign word_if.word_bits  = head.bits;
    assign word_if.word_last  = head.last;
    assign word_if.word_valid = word_valid;

endmodule

// File: tb/tb_sign_wbuf.sv
// Scoreboard bench for sign_wbuf: expected words queued at drive time, compared on each pop.
module tb_sign_wbuf;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [63:0] sign_in;
    logic [5:0]  size_in;
    logic        des_wr;
    logic        last_wr;
    logic        last_ack;
    logic [3:0]  fill;
    logic        overflow;

    sign_wbuf_if word_if ();

    sign_wbuf dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .sign_in  (sign_in),
        .size_in  (size_in),
        .des_wr   (des_wr),
        .last_wr  (last_wr),
        .last_ack (last_ack),
        .word_if  (word_if.master),
        .fill     (fill),
        .overflow (overflow)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [71:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [71:0] full_e(input logic [63:0] d);
        return {d, 7'd64, 1'b0};
    endfunction

    function automatic logic [71:0] part_e(input logic [63:0] d, input logic [5:0] s);
        return {d, 1'b0, s, 1'b1};
    endfunction

    // Pop monitor: a handshake seen mid-cycle completes at the next posedge.
    initial begin
        logic [71:0] exp_e;
        forever begin
            @(negedge clk);
            if (rst && word_if.word_valid && word_if.word_ready) begin
                check("pop_expected", 72'(sb.size() != 0), 72'd1);
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    check("pop_word",
                          {word_if.word_out, word_if.word_bits, word_if.word_last}, exp_e);
                end
            end
        end
    end

    initial begin
        logic [63:0] d;
        rst = 1'b0;
        clk_en = 1'b0;
        sign_in = '0;
        size_in = '0;
        des_wr = 1'b0;
        last_wr = 1'b0;
        word_if.word_ready = 1'b0;
        step(2);
        check("rst_fill", 72'(fill), 72'd0);
        check("rst_valid", 72'(word_if.word_valid), 72'd0);
        check("rst_ack", 72'(last_ack), 72'd0);
        check("rst_ovf", 72'(overflow), 72'd0);
        rst = 1'b1;
        step(1);

        // Full words A, B, C
        clk_en = 1'b1;
        word_if.word_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = 64'hA0A0_0000_0000_0000 + 64'(i);
            sign_in = d;
            des_wr = 1'b1;
            sb.push_back(full_e(d));
            step(1);
        end
        des_wr = 1'b0;
        step(3);
        check("full_drained", 72'(sb.size()), 72'd0);
        check("full_fill", 72'(fill), 72'd0);

        // Partial word, ack held while clk_en low, last_wr ignored in L_ACK
        d = 64'hFFF8_0000_0000_0000;
        sign_in = d;
        size_in = 6'd13;
        last_wr = 1'b1;
        sb.push_back(part_e(d, 6'd13));
        step(1);
        check("part_ack1", 72'(last_ack), 72'd1);
        clk_en = 1'b0;
        step(2);
        check("part_ack_hold", 72'(last_ack), 72'd1);
        clk_en = 1'b1;
        step(1);
        check("part_ack_drop", 72'(last_ack), 72'd0);
        last_wr = 1'b0;
        step(3);
        check("part_drained", 72'(sb.size()), 72'd0);
        check("part_fill", 72'(fill), 72'd0);

        // Collision: des_wr wins, partial follows
        d = 64'h1234_5678_9ABC_DEF0;
        sign_in = d;
        des_wr = 1'b1;
        last_wr = 1'b1;
        size_in = 6'd20;
        sb.push_back(full_e(d));
        step(1);
        check("coll_ack0", 72'(last_ack), 72'd0);
        des_wr = 1'b0;
        d = 64'hCAFE_B000_0000_0000;
        sign_in = d;
        sb.push_back(part_e(d, 6'd20));
        step(1);
        check("coll_ack1", 72'(last_ack), 72'd1);
        last_wr = 1'b0;
        step(3);
        check("coll_drained", 72'(sb.size()), 72'd0);

        // Overflow: 9 writes into a stalled FIFO
        word_if.word_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d = 64'h5500_0000_0000_0000 + 64'(i * 3 + 1);
            sign_in = d;
            des_wr = 1'b1;
            if (i < 8) sb.push_back(full_e(d));
            step(1);
            if (i == 7) begin
                check("ovf_fill8", 72'(fill), 72'd8);
                check("ovf_not_yet", 72'(overflow), 72'd0);
            end
        end
        des_wr = 1'b0;
        check("ovf_fill_full", 72'(fill), 72'd8);
        check("ovf_flag", 72'(overflow), 72'd1);
        word_if.word_ready = 1'b1;
        step(10);
        check("ovf_drained", 72'(sb.size()), 72'd0);
        check("ovf_fill0", 72'(fill), 72'd0);
        check("ovf_sticky", 72'(overflow), 72'd1);

        // clk_en gating
        word_if.word_ready = 1'b0;
        clk_en = 1'b0;
        des_wr = 1'b1;
        sign_in = 64'hDEAD_DEAD_DEAD_DEAD;
        step(2);
        check("gate_nowr", 72'(fill), 72'd0);
        clk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = 64'h7700_0000_0000_0010 + 64'(i);
            sign_in = d;
            sb.push_back(full_e(d));
            step(1);
        end
        des_wr = 1'b0;
        check("gate_fill2", 72'(fill), 72'd2);
        clk_en = 1'b0;
        word_if.word_ready = 1'b1;
        step(1);
        check("gate_pop1", 72'(fill), 72'd1);
        step(1);
        check("gate_pop2", 72'(fill), 72'd0);
        check("gate_drained", 72'(sb.size()), 72'd0);

        // size_in=0: acknowledged, nothing written
        clk_en = 1'b1;
        last_wr = 1'b1;
        size_in = 6'd0;
        step(1);
        check("size0_ack", 72'(last_ack), 72'd1);
        check("size0_fill", 72'(fill), 72'd0);
        last_wr = 1'b0;
        step(2);
        check("size0_idle", 72'(last_ack), 72'd0);

        // Reset with fill=5 and FSM in L_ACK
        word_if.word_ready = 1'b0;
        des_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sign_in = 64'h9900_0000_0000_0000 + 64'(i);
            step(1);
        end
        des_wr = 1'b0;
        last_wr = 1'b1;
        size_in = 6'd7;
        step(1);
        last_wr = 1'b0;
        clk_en = 1'b0;
        step(1);
        check("pre_rst_fill", 72'(fill), 72'd5);
        check("pre_rst_ack", 72'(last_ack), 72'd1);
        rst = 1'b0;
        step(1);
        check("mid_rst_fill", 72'(fill), 72'd0);
        check("mid_rst_valid", 72'(word_if.word_valid), 72'd0);
        check("mid_rst_ack", 72'(last_ack), 72'd0);
        check("mid_rst_ovf", 72'(overflow), 72'd0);
        rst = 1'b1;
        clk_en = 1'b1;
        word_if.word_ready = 1'b1;
        d = 64'h0BAD_F00D_0000_0001;
        sign_in = d;
        des_wr = 1'b1;
        sb.push_back(full_e(d));
        step(1);
        des_wr = 1'b0;
        step(3);
        check("post_rst_drained", 72'(sb.size()), 72'd0);
        check("post_rst_fill", 72'(fill), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sign_wbuf.md
SIGN_WBUF -- requirements
Module: sign_wbuf

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset: clk and rst (rst low = reset), both sampled on posedge clk.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- clk_en  in  1  upstream clock enable; gates the write side only.
- sign_in  in  64  word from the deserializer; MSB-first, valid bits [63:64-size] when partial.
- size_in  in  6  bit count of a partial word, valid while last_wr=1.
- des_wr  in  1  one-cycle full-word strobe, qualified by clk_en; no backpressure possible.
- last_wr  in  1  level; a partial last word is pending until acknowledged.
- last_ack  out  1  acknowledge for last_wr.
- word_out  out  64  buffered word.
- word_bits  out  7  valid bits in word_out, 1..64.
- word_last  out  1  word_out is the final (partial) word of a slice.
- word_valid  out  1  output handshake valid.
- word_ready  in  1  output handshake ready.
- fill  out  4  FIFO occupancy, 0..8.
- overflow  out  1  sticky: a full word was dropped.

Function
REQ-003 SHALL buffer entries {data[63:0], bits[6:0], last} in an 8-deep synchronous FIFO.
REQ-004 SHALL write {sign_in, 64, 0} on every cycle with clk_en=1 and des_wr=1 when the FIFO is not full, or when it is full and a read occurs that same cycle.
REQ-005 SHALL, when des_wr is dropped due to a full FIFO, set overflow=1 and hold it until reset.
REQ-006 SHALL implement an ack FSM with states L_IDLE and L_ACK; last_ack=1 only in L_ACK.
REQ-007 SHALL transition L_IDLE->L_ACK and write {sign_in, zero-extended size_in, 1} when clk_en=1, last_wr=1, des_wr=0 and a FIFO slot is free (read-same-cycle counts as free).
REQ-008 SHALL give des_wr priority over a pending last_wr in the same cycle; the last word stays pending.
REQ-009 SHALL stay in L_ACK until a cycle with clk_en=1, then return to L_IDLE; last_wr SHALL be ignored while in L_ACK (no duplicate write).
REQ-010 SHALL treat size_in=0 with last_wr=1 as an error-free no-op: acknowledge without writing a FIFO entry.
REQ-011 SHALL present the head entry on word_out/word_bits/word_last with word_valid=1 whenever fill>0; zero added latency beyond one cycle from write to word_valid.
REQ-012 SHALL pop on word_valid && word_ready, independent of clk_en.
REQ-013 SHALL hold word_out/word_bits/word_last stable while word_valid=1 and word_ready=0.
REQ-014 SHALL update fill by +1 on write, -1 on read, unchanged on simultaneous read and write; pointers wrap modulo 8.
REQ-015 SHALL preserve arrival order of full and last words.

Reset
REQ-016 SHALL, on rst=0 at posedge clk: fill=0, word_valid=0, last_ack=0, FSM=L_IDLE, overflow=0, pointers=0; FIFO data storage not reset.
REQ-017 SHALL abandon any in-flight entry or pending ack on reset mid-operation; the first cycle after reset behaves as from power-up.

Structure
REQ-018 SHALL place WORD_W=64, SIZE_W=6, BITS_W=7, FIFO_DEPTH=8, the entry struct type and the FSM enum in a shared package.
REQ-019 SHALL instantiate one sub-module, sign_fifo, holding storage, pointers and fill; FSM and write arbitration live in sign_wbuf.

Verification
REQ-020 SHALL cover these scenarios:
- Full words: 3 des_wr pulses (A, B, C), word_ready=1 -> 3 outputs A, B, C, word_bits=64, word_last=0.
- Partial word: last_wr=1, size_in=13 -> one output with word_bits=13, word_last=1; last_ack high exactly until the first clk_en cycle; no duplicate entry.
- Collision: des_wr and last_wr in the same cycle -> full word output first, then the partial word.
- Overflow: word_ready=0 with 9 des_wr pulses -> fill=8, overflow=1, 9th word absent; then drain -> first 8 words in order.
- clk_en gating: des_wr=1 with clk_en=0 -> no write; pop with clk_en=0 and word_ready=1 -> fill decrements.
- Reset with fill=5 and FSM in L_ACK -> fill=0, word_valid=0, last_ack=0 next cycle.
